btn_click_decoder: RTL



---
 rtl/btn_evt_pkg.sv | 30 +++
 rtl/btn_release_filter.sv | 30 +++
 rtl/btn_click_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and default timing constants for the button gesture decoder.
package btn_evt_pkg;

    localparam int unsigned CNT_W_DEF      = 26;
    localparam int unsigned DCLICK_WIN_DEF = 15_000_000;
    localparam int unsigned LONG_HOLD_DEF  = 50_000_000;
    localparam int unsigned REL_FILT_DEF   = 500_000;
    localparam int unsigned REPEAT_PER_DEF = 10_000_000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        HOLD_LONG = 3'd4
    } btn_state_e;

    // One bit per classified gesture; at most one is set in any cycle.
    typedef struct packed {
        logic single_click;
        logic double_click;
        logic long_press;
    } btn_evt_t;

    // True when a terminal count of 'limit' cycles fits a timer of 'width' bits.
    function automatic logic cnt_fits(input int unsigned limit, input int unsigned width);
        return (64'(limit) <= (64'(1) << width));
    endfunction

endpackage

// File: rtl/btn_release_filter.sv
// Release qualifier: flags the cycle in which held_i has been low for REL_FILT consecutive cycles.
module btn_release_filter
    import btn_evt_pkg::*;
#(
    parameter int unsigned REL_FILT = REL_FILT_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic held_i,
    output logic released_c
);

    localparam int unsigned  RW   = (REL_FILT > 2) ? $clog2(REL_FILT) : 1;
    localparam logic [RW-1:0] LAST = RW'(REL_FILT - 1);

    logic [RW-1:0] r_rel_cnt;

    // Counts prior low cycles; any high sample restarts the filter, count saturates at LAST.
    always_ff @(posedge clk) begin
        if (clear || held_i) begin
            r_rel_cnt <= '0;
        end else if (r_rel_cnt != LAST) begin
            r_rel_cnt <= r_rel_cnt + RW'(1);
        end
    end

    // The current low sample completes the run, so a shorter dropout never qualifies.
    assign released_c = !held_i && (r_rel_cnt == LAST);

endmodule

// File: rtl/btn_click_decoder.sv
// Classifies debounced button gestures into single, double and long-press pulses.
// Optional macro BTN_LONG_REPEAT_EN: long_o repeats every REPEAT_PER cycles while held.
module btn_click_decoder
    import btn_evt_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DCLICK_WIN = DCLICK_WIN_DEF,
    parameter int unsigned LONG_HOLD  = LONG_HOLD_DEF,
    parameter int unsigned REL_FILT   = REL_FILT_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic press_i,
    input  logic held_i,
    output logic single_o,
    output logic double_o,
    output logic long_o,
    output logic busy_o
);

    // Reject timer limits that are zero or would not fit the gesture timer.
    if (!cnt_fits(DCLICK_WIN, CNT_W) || !cnt_fits(LONG_HOLD, CNT_W) ||
        !cnt_fits(REPEAT_PER, CNT_W) || (DCLICK_WIN == 0) || (LONG_HOLD == 0) ||
        (REPEAT_PER == 0) || (REL_FILT == 0)) begin : g_param_err
        $error("btn_click_decoder: timing parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_WIN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_HOLD - 1);
`ifdef BTN_LONG_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PER - 1);
`endif

    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_timer_run;
    logic             w_timer_clr;
    btn_evt_t         r_evt;
    btn_evt_t         w_evt_nxt;
    logic             r_busy;
    logic             w_released;

    btn_release_filter #(
        .REL_FILT   (REL_FILT)
    ) u_rel_filt (
        .clk        (CLOCK_50),
        .clear      (reset),
        .held_i     (held_i),
        .released_c (w_released)
    );

    // State, timer and registered event outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_evt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_evt   <= w_evt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Gesture classification; release outranks the long deadline, a press outranks the window timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_evt_nxt   = '0;
        w_timer_run = 1'b0;
        w_timer_clr = 1'b0;

        case (r_state)
            IDLE: begin
                if (press_i) begin
                    w_state_nxt = PRESS1;
                end
            end

            PRESS1: begin
                w_timer_run = 1'b1;
                if (w_released) begin
                    w_state_nxt = WAIT2;
                end else if (r_timer == LONG_LAST) begin
                    w_state_nxt          = HOLD_LONG;
                    w_evt_nxt.long_press = 1'b1;
                end
            end

            WAIT2: begin
                w_timer_run = 1'b1;
                if (press_i) begin
                    w_state_nxt            = PRESS2;
                    w_evt_nxt.double_click = 1'b1;
                end else if (r_timer == DCLICK_LAST) begin
                    w_state_nxt            = IDLE;
                    w_evt_nxt.single_click = 1'b1;
                end
            end

            PRESS2: begin
                if (w_released) begin
                    w_state_nxt = IDLE;
                end
            end

            HOLD_LONG: begin
`ifdef BTN_LONG_REPEAT_EN
                w_timer_run = 1'b1;
                if (w_released) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == REPEAT_LAST) begin
                    w_evt_nxt.long_press = 1'b1;
                    w_timer_clr          = 1'b1;
                end
`else
                if (w_released) begin
                    w_state_nxt = IDLE;
                end
`endif
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Every state entry restarts the timer from zero.
        if (w_state_nxt != r_state) begin
            w_timer_clr = 1'b1;
        end

        if (w_timer_clr) begin
            w_timer_nxt = '0;
        end else if (w_timer_run) begin
            w_timer_nxt = r_timer + CNT_W'(1);
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    assign single_o = r_evt.single_click;
    assign double_o = r_evt.double_click;
    assign long_o   = r_evt.long_press;
    assign busy_o   = r_busy;

endmodule
